core_ifu: RTL

- Instruction fetch unit of the RV32I pipeline; responder to the hazard control unit's PC-write/stall and branch-redirect outputs.
- Owns the PC and issues single-outstanding reads on the instruction-memory read channel (AR/R valid/ready).
- Presents fetched instruction plus PC to the IF/ID boundary.
- Holds that output while stalled, and kills wrong-path fetches on a taken branch.

---
 rtl/core_ifu.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/core_ifu.sv
// core_ifu: RV32I fetch unit, one outstanding AR/R read; optional trap under IFU_MISALIGN_TRAP_EN.
// Latency: IF/ID valid 1 cycle after the R handshake; at best one instruction per 2 cycles.
// Backpressure: HCU_PC_WRITE=0 holds IF/ID and drops RREADY while IF/ID holds a live instruction.
module core_ifu #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        HCU_PC_WRITE,
  input  logic        C_TAKE_BRANCH,
  input  logic [31:0] BRANCH_TARGET,
  output logic        IMEM_ARVALID,
  input  logic        IMEM_ARREADY,
  output logic [31:0] IMEM_ARADDR,
  input  logic        IMEM_RVALID,
  output logic        IMEM_RREADY,
  input  logic [31:0] IMEM_RDATA,
  output logic        IFID_VALID,
  output logic [31:0] IFID_INSTR,
  output logic [31:0] IFID_PC
`ifdef IFU_MISALIGN_TRAP_EN
  ,
  output logic        IFU_MISALIGN
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] araddr;
  logic        kill;
  logic        run;
  logic        ar_ok;
  logic        ar_hs;
  logic        r_hs;
  logic        capture;

`ifdef IFU_MISALIGN_TRAP_EN
  logic misalign;
  assign ar_ok        = (araddr[1:0] == 2'b00);
  assign IFU_MISALIGN = misalign;
`else
  assign ar_ok = 1'b1;
`endif

  assign IMEM_ARADDR = araddr;
  assign ar_hs       = IMEM_ARVALID & IMEM_ARREADY;
  assign r_hs        = IMEM_RVALID & IMEM_RREADY;
  assign capture     = (state == S_WAIT) & r_hs & ~C_TAKE_BRANCH;

  always_ff @(posedge CLK) begin
    if (RST) state <= S_REQ;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ: begin
        if (ar_hs) state_nxt = (kill | C_TAKE_BRANCH) ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (C_TAKE_BRANCH) state_nxt = IMEM_RVALID ? S_REQ : S_DROP;
        else if (r_hs)     state_nxt = S_REQ;
      end
      S_DROP: begin
        // A branch that coincides with the dropped beat must not wait for a second beat.
        if (IMEM_RVALID) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_comb begin
    IMEM_ARVALID = 1'b0;
    IMEM_RREADY  = 1'b0;
    case (state)
      S_REQ:   IMEM_ARVALID = run & ar_ok;
      S_WAIT:  IMEM_RREADY  = HCU_PC_WRITE | ~IFID_VALID | C_TAKE_BRANCH;
      S_DROP:  IMEM_RREADY  = 1'b1;
      default: IMEM_RREADY  = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc         <= RESET_PC;
      araddr     <= RESET_PC;
      kill       <= 1'b0;
      run        <= 1'b0;
      IFID_VALID <= 1'b0;
      IFID_INSTR <= NOP_INSTR;
      IFID_PC    <= RESET_PC;
    end else begin
      run <= 1'b1;

      if (C_TAKE_BRANCH) pc <= BRANCH_TARGET;
      else if (capture)  pc <= araddr + 32'd4;

      case (state)
        S_REQ: begin
          // An address already on the bus must stay put; an unissued one can be redirected.
          if (ar_hs)              kill   <= 1'b0;
          else if (C_TAKE_BRANCH) begin
            if (IMEM_ARVALID)     kill   <= 1'b1;
            else                  araddr <= BRANCH_TARGET;
          end
        end
        S_WAIT: begin
          if (C_TAKE_BRANCH && IMEM_RVALID) araddr <= BRANCH_TARGET;
          else if (capture)                 araddr <= araddr + 32'd4;
        end
        S_DROP: begin
          if (IMEM_RVALID) begin
            kill   <= 1'b0;
            araddr <= C_TAKE_BRANCH ? BRANCH_TARGET : pc;
          end
        end
        default: kill <= 1'b0;
      endcase

      if (C_TAKE_BRANCH) begin
        IFID_VALID <= 1'b0;
        IFID_INSTR <= NOP_INSTR;
      end else if (capture) begin
        IFID_VALID <= 1'b1;
        IFID_INSTR <= IMEM_RDATA;
        IFID_PC    <= araddr;
      end else if (HCU_PC_WRITE) begin
        IFID_VALID <= 1'b0;
        IFID_INSTR <= NOP_INSTR;
      end
    end
  end

`ifdef IFU_MISALIGN_TRAP_EN
  always_ff @(posedge CLK) begin
    if (RST)
      misalign <= 1'b0;
    else if (C_TAKE_BRANCH && (BRANCH_TARGET[1:0] == 2'b00))
      misalign <= 1'b0;
    else if ((state == S_REQ) && run && !ar_ok)
      misalign <= 1'b1;
  end
`endif

endmodule
